// File: rtl/vectored_interrupt_control_unit.sv
// Prioritised, maskable interrupt sequencer for the single-cycle core: drains the pipeline,
// redirects to a per-source vector, and returns to the captured PC.
module vectored_interrupt_control_unit #(
  parameter int unsigned ADDRESS_BITS  = 20,
  parameter int unsigned NUM_SOURCES   = 4,
  parameter int unsigned VECTOR_BASE   = 'h100,
  parameter int unsigned VECTOR_STRIDE = 16,
  localparam int unsigned ID_BITS      = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_SOURCES-1:0]  irq_request,
  input  logic [NUM_SOURCES-1:0]  irq_enable,
  input  logic                    global_enable,
  input  logic                    pipeline_idle,
  input  logic [ADDRESS_BITS-1:0] issue_PC,
  input  logic                    instr_retire,
  input  logic                    interrupt_return,
  output logic                    interrupt_stall,
  output logic                    interrupt_jump,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic [ADDRESS_BITS-1:0] saved_PC,
  output logic                    interrupt_done,
  output logic                    interrupt_active,
  output logic [NUM_SOURCES-1:0]  irq_ack,
  output logic [ID_BITS-1:0]      active_id
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_JUMP,
    ST_ACTIVE,
    ST_RETURN
  } state_t;

  localparam logic [ADDRESS_BITS-1:0] BASE_ADDR   = ADDRESS_BITS'(VECTOR_BASE);
  localparam logic [ADDRESS_BITS-1:0] STRIDE_ADDR = ADDRESS_BITS'(VECTOR_STRIDE);

  state_t                  state_q, state_d;
  logic                    guard_q, guard_d;
  logic [ADDRESS_BITS-1:0] saved_pc_q, saved_pc_d;
  logic [ID_BITS-1:0]      active_id_q, active_id_d;

  logic [NUM_SOURCES-1:0]  pending;
  logic [ID_BITS-1:0]      winner;
  logic [ADDRESS_BITS-1:0] vector_pc;

  // Lowest index wins: scan downwards so the last hit is the smallest set bit.
  always_comb begin
    pending = irq_request & irq_enable & {NUM_SOURCES{global_enable}};
    winner  = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (pending[i]) winner = ID_BITS'(i);
    end
  end

  // Product and sum wrap modulo 2**ADDRESS_BITS by construction.
  assign vector_pc = BASE_ADDR + ADDRESS_BITS'(active_id_q) * STRIDE_ADDR;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the combinational process below uses blocking assignments.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      guard_q     <= 1'b0;
      saved_pc_q  <= '0;
      active_id_q <= '0;
    end else begin
      state_q     <= state_d;
      guard_q     <= guard_d;
      saved_pc_q  <= saved_pc_d;
      active_id_q <= active_id_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d          = state_q;
    guard_d          = guard_q;
    saved_pc_d       = saved_pc_q;
    active_id_d      = active_id_q;
    interrupt_stall  = 1'b0;
    interrupt_jump   = 1'b0;
    interrupt_done   = 1'b0;
    interrupt_active = 1'b0;
    target_PC        = '0;
    irq_ack          = '0;

    unique case (state_q)
      ST_IDLE: begin
        // A retire clears the guard, but the request seen this cycle still waits one more.
        if (guard_q && instr_retire) guard_d = 1'b0;
        if (!guard_q && (pending != '0)) begin
          active_id_d = winner;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        interrupt_stall = 1'b1;
        if (pipeline_idle) begin
          saved_pc_d = issue_PC;
          state_d    = ST_JUMP;
        end
      end
      ST_JUMP: begin
        interrupt_jump   = 1'b1;
        interrupt_active = 1'b1;
        target_PC        = vector_pc;
        irq_ack          = NUM_SOURCES'(1) << active_id_q;
        state_d          = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        interrupt_active = 1'b1;
        if (interrupt_return) state_d = ST_RETURN;
      end
      ST_RETURN: begin
        interrupt_jump = 1'b1;
        interrupt_done = 1'b1;
        target_PC      = saved_pc_q;
        guard_d        = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign saved_PC  = saved_pc_q;
  assign active_id = active_id_q;

endmodule

// File: tb/tb_vectored_interrupt_control_unit.sv
// Scoreboard bench: the driver pushes expected jump events, a negedge monitor pops and compares.
module tb_vectored_interrupt_control_unit;

  localparam int AB  = 20;
  localparam int NS  = 4;
  localparam int VB  = 'h100;
  localparam int VS  = 16;
  localparam int IDB = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NS-1:0] irq_request = '0;
  logic [NS-1:0] irq_enable = '0;
  logic          global_enable = 1'b0;
  logic          pipeline_idle = 1'b0;
  logic [AB-1:0] issue_PC = '0;
  logic          instr_retire = 1'b0;
  logic          interrupt_return = 1'b0;
  logic          interrupt_stall, interrupt_jump, interrupt_done, interrupt_active;
  logic [AB-1:0] target_PC, saved_PC;
  logic [NS-1:0] irq_ack;
  logic [IDB-1:0] active_id;

  vectored_interrupt_control_unit #(
    .ADDRESS_BITS(AB), .NUM_SOURCES(NS), .VECTOR_BASE(VB), .VECTOR_STRIDE(VS)
  ) dut (
    .clock(clock), .reset(reset),
    .irq_request(irq_request), .irq_enable(irq_enable), .global_enable(global_enable),
    .pipeline_idle(pipeline_idle), .issue_PC(issue_PC), .instr_retire(instr_retire),
    .interrupt_return(interrupt_return),
    .interrupt_stall(interrupt_stall), .interrupt_jump(interrupt_jump),
    .target_PC(target_PC), .saved_PC(saved_PC), .interrupt_done(interrupt_done),
    .interrupt_active(interrupt_active), .irq_ack(irq_ack), .active_id(active_id)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit            is_return;
    int            cyc;
    logic [AB-1:0] target;
    logic [NS-1:0] ack;
    logic [IDB-1:0] id;
    logic [AB-1:0] saved;
    int            stall;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  logic [AB-1:0] last_saved = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: lowest set bit of the masked request vector, vector address mod 2**AB.
  function automatic int lowest_set(input logic [NS-1:0] p);
    for (int i = 0; i < NS; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic logic [AB-1:0] vector_of(input int id);
    longint t;
    t = longint'(VB) + longint'(id) * longint'(VS);
    return AB'(t);
  endfunction

  // Monitor
  int   stall_cnt = 0;
  exp_t m;
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        stall_cnt = 0;
      end else begin
        if (interrupt_stall) stall_cnt++;
        if (interrupt_jump) begin
          check("jump_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            m = exp_q.pop_front();
            check("jump_cycle", 64'(cyc), 64'(m.cyc));
            check("target_PC", 64'(target_PC), 64'(m.target));
            check("saved_PC", 64'(saved_PC), 64'(m.saved));
            check("irq_ack", 64'(irq_ack), 64'(m.ack));
            if (m.is_return) begin
              check("return_flags{active,done,stall}",
                    64'({interrupt_active, interrupt_done, interrupt_stall}), 64'(3'b010));
            end else begin
              check("active_id", 64'(active_id), 64'(m.id));
              check("stall_cycles", 64'(stall_cnt), 64'(m.stall));
              check("entry_flags{active,done,stall}",
                    64'({interrupt_active, interrupt_done, interrupt_stall}), 64'(3'b100));
            end
          end
          stall_cnt = 0;
        end else begin
          check("strobes_without_jump{ack,done}", 64'({irq_ack, interrupt_done}), 64'(0));
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_entry(input logic [NS-1:0] req, input logic [NS-1:0] en, input logic ge,
                           input int d, input logic [AB-1:0] pc_final,
                           input bit use_retire, input bit scramble);
    exp_t e;
    int   id;
    int   t0;
    id = lowest_set(req & en & {NS{ge}});
    t0 = cyc;
    irq_request = req; irq_enable = en; global_enable = ge;
    pipeline_idle = 1'b0; instr_retire = use_retire; interrupt_return = 1'b0;
    issue_PC = AB'($urandom);
    step();
    instr_retire = 1'b0;
    if (use_retire) step();
    for (int k = 0; k < d; k++) begin
      issue_PC = AB'($urandom);
      if (scramble) begin
        irq_request = NS'($urandom);
        irq_enable = NS'($urandom);
        global_enable = 1'($urandom);
        interrupt_return = 1'($urandom);
      end
      step();
    end
    issue_PC = pc_final; pipeline_idle = 1'b1; interrupt_return = 1'b0;
    e.is_return = 1'b0;
    e.cyc       = t0 + 2 + int'(use_retire) + d;
    e.target    = vector_of(id);
    e.ack       = '0;
    e.ack[id]   = 1'b1;
    e.id        = IDB'(id);
    e.saved     = pc_final;
    e.stall     = d + 1;
    exp_q.push_back(e);
    last_saved = pc_final;
    step();
  endtask

  task automatic run_return(input int w, input bit scramble);
    exp_t e;
    repeat (w + 1) begin
      if (scramble) irq_request = NS'($urandom);
      step();
    end
    interrupt_return = 1'b1;
    e.is_return = 1'b1;
    e.cyc       = cyc + 1;
    e.target    = last_saved;
    e.ack       = '0;
    e.id        = '0;
    e.saved     = last_saved;
    e.stall     = 0;
    exp_q.push_back(e);
    step();
    interrupt_return = 1'b0;
    step();
  endtask

  task automatic clear_guard();
    irq_request = '0;
    instr_retire = 1'b1;
    step();
    instr_retire = 1'b0;
  endtask

  task automatic hold_quiet(input string name, input int n, input bit poke);
    repeat (n) begin
      if (poke) begin
        interrupt_return = 1'($urandom);
        instr_retire = 1'($urandom);
      end
      step();
      check({name, "_stall"}, 64'(interrupt_stall), 64'(0));
      check({name, "_active"}, 64'(interrupt_active), 64'(0));
    end
    interrupt_return = 1'b0;
    instr_retire = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_strobes"},
          64'({interrupt_stall, interrupt_jump, interrupt_done, interrupt_active, irq_ack}), 64'(0));
    check({name, "_target_PC"}, 64'(target_PC), 64'(0));
    check({name, "_saved_PC"}, 64'(saved_PC), 64'(0));
    check({name, "_active_id"}, 64'(active_id), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS-1:0] req, en;
    logic          ge;

    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("por");
    #2 reset = 1'b1;

    // Single source
    run_entry(4'b0100, 4'b1111, 1'b1, 0, 20'h00040, 1'b0, 1'b0);
    run_return(1, 1'b0);
    // Guard: request still held, no re-entry until a retire in IDLE
    hold_quiet("guard_hold", 3, 1'b0);
    run_entry(4'b0100, 4'b1111, 1'b1, 0, 20'h00a5c, 1'b1, 1'b0);
    run_return(0, 1'b0);
    clear_guard();

    // Priority and mask
    run_entry(4'b1010, 4'b1000, 1'b1, 0, 20'h01234, 1'b0, 1'b0);
    run_return(2, 1'b0);
    clear_guard();
    run_entry(4'b1010, 4'b1111, 1'b1, 0, 20'h05678, 1'b0, 1'b0);
    run_return(0, 1'b0);
    clear_guard();

    // Drain hold of 5 cycles with request/mask/return churn in DRAIN
    run_entry(4'b0001, 4'b1111, 1'b1, 5, 20'hfffff, 1'b0, 1'b1);
    run_return(3, 1'b1);
    clear_guard();

    // Ignored events
    irq_request = 4'b1111; irq_enable = 4'b1111; global_enable = 1'b0;
    hold_quiet("global_off", 4, 1'b1);
    irq_request = '0; global_enable = 1'b1;
    hold_quiet("return_in_idle", 3, 1'b1);

    // Reset mid-DRAIN
    irq_request = 4'b0100; irq_enable = 4'b1111; global_enable = 1'b1; pipeline_idle = 1'b0;
    step();
    step();
    #1 reset = 1'b0;
    #1 check_reset_outputs("reset_drain");
    irq_request = '0; pipeline_idle = 1'b1;
    step();
    #2 reset = 1'b1;
    run_entry(4'b1000, 4'b1111, 1'b1, 1, 20'h00777, 1'b0, 1'b0);

    // Reset mid-ACTIVE
    step();
    step();
    #1 reset = 1'b0;
    #1 check_reset_outputs("reset_active");
    irq_request = '0;
    step();
    #2 reset = 1'b1;
    run_entry(4'b0010, 4'b0110, 1'b1, 0, 20'h00321, 1'b0, 1'b0);
    run_return(1, 1'b0);
    clear_guard();

    // Randomised transactions
    for (int n = 0; n < 40; n++) begin
      req = NS'($urandom);
      en  = NS'($urandom);
      ge  = ($urandom % 4) != 0;
      if ((req & en & {NS{ge}}) != '0) begin
        run_entry(req, en, ge, int'($urandom % 4), AB'($urandom), 1'b0, 1'b1);
        run_return(int'($urandom % 3), 1'b1);
        clear_guard();
      end else begin
        irq_request = req; irq_enable = en; global_enable = ge;
        hold_quiet("no_pending", 3, 1'b1);
      end
    end

    step();
    step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
